// File: rtl/median_frame_seq.sv
// rtl/median_frame_seq.sv - frame sequencer for the 3x3 median datapath: window requests, lane packing, output word writes
// Optional MEDF_STATS_EN adds the stat_pix / stat_stall counters.
module median_frame_seq #(
    parameter int PIX_W        = 16,
    parameter int LANES        = 2,
    parameter int PIX_PER_WORD = 4,
    parameter int DIM_W        = 16,
    parameter int ADDR_W       = 21
) (
    input  logic                          pclk,
    input  logic                          prst,
    input  logic                          start,
    input  logic [DIM_W-1:0]              frame_width,
    input  logic [DIM_W-1:0]              frame_height,
    input  logic [ADDR_W-1:0]             wr_base,
    output logic                          win_req,
    output logic [DIM_W-1:0]              win_col,
    output logic [DIM_W-1:0]              win_row,
    input  logic                          win_ack,
    input  logic                          med_valid,
    input  logic [LANES*PIX_W-1:0]        med_data,
    output logic                          med_ready,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_adr,
    output logic [PIX_PER_WORD*PIX_W-1:0] wr_data,
    input  logic                          wr_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          dim_err
`ifdef MEDF_STATS_EN
    ,
    output logic [31:0]                   stat_pix,
    output logic [31:0]                   stat_stall
`endif
);

    // Two words of buffer: a step straddling a word boundary spills into the upper half.
    localparam int BUF_N = 2 * PIX_PER_WORD;
    localparam int CNT_W = $clog2(BUF_N + 1);
    localparam logic [CNT_W-1:0] PPW_C = CNT_W'(PIX_PER_WORD);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;

    state_t           state;
    logic [DIM_W-1:0] wm2, hm2, col, row;
    logic [CNT_W-1:0] fill;
    logic             last_step;
    logic [PIX_W-1:0] pbuf [BUF_N];

    logic [DIM_W-1:0] rem_cols, n_valid, col_nx, row_nx;
    logic [CNT_W-1:0] fill_nx, fill_rem;
    logic             last_nx;

    assign win_col = col;
    assign win_row = row;

    always_comb begin
        rem_cols = wm2 - col;
        n_valid  = (rem_cols < DIM_W'(LANES)) ? rem_cols : DIM_W'(LANES);
        fill_nx  = fill + CNT_W'(n_valid);
        col_nx   = col + DIM_W'(LANES);
        row_nx   = row;
        if (col_nx >= wm2) begin
            col_nx = '0;
            row_nx = row + DIM_W'(1);
        end
        last_nx  = (row_nx == hm2);
        fill_rem = (fill >= PPW_C) ? fill - PPW_C : '0;
        for (int k = 0; k < PIX_PER_WORD; k++)
            wr_data[k*PIX_W +: PIX_W] = pbuf[k];
    end

`ifdef MEDF_STATS_EN
    logic [CNT_W-1:0] word_pix;
    assign word_pix = (fill >= PPW_C) ? PPW_C : fill;
`endif

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state     <= S_IDLE;
            wm2       <= '0;
            hm2       <= '0;
            col       <= '0;
            row       <= '0;
            fill      <= '0;
            last_step <= 1'b0;
            for (int j = 0; j < BUF_N; j++) pbuf[j] <= '0;
            win_req   <= 1'b0;
            med_ready <= 1'b0;
            wr_en     <= 1'b0;
            wr_adr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dim_err   <= 1'b0;
`ifdef MEDF_STATS_EN
            stat_pix   <= '0;
            stat_stall <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    wm2       <= frame_width - DIM_W'(2);
                    hm2       <= frame_height - DIM_W'(2);
                    col       <= '0;
                    row       <= '0;
                    fill      <= '0;
                    last_step <= 1'b0;
                    wr_adr    <= wr_base;
                    for (int j = 0; j < BUF_N; j++) pbuf[j] <= '0;
`ifdef MEDF_STATS_EN
                    stat_pix   <= '0;
                    stat_stall <= '0;
`endif
                    if (frame_width < DIM_W'(3) || frame_height < DIM_W'(3)) begin
                        dim_err <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        dim_err <= 1'b0;
                        busy    <= 1'b1;
                        win_req <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: if (win_ack) begin
                    win_req   <= 1'b0;
                    med_ready <= 1'b1;
                    state     <= S_WAIT;
                end
                S_WAIT: if (med_valid) begin
                    // Lanes past the row end are dropped; kept lanes land at fill, fill+1, ...
                    for (int j = 0; j < BUF_N; j++)
                        for (int i = 0; i < LANES; i++)
                            if (DIM_W'(i) < n_valid && CNT_W'(j) == fill + CNT_W'(i))
                                pbuf[j] <= med_data[i*PIX_W +: PIX_W];
                    fill      <= fill_nx;
                    col       <= col_nx;
                    row       <= row_nx;
                    last_step <= last_nx;
                    med_ready <= 1'b0;
                    if (fill_nx >= PPW_C || last_nx) begin
                        wr_en <= 1'b1;
                        state <= S_WRITE;
                    end else begin
                        win_req <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        wr_adr <= wr_adr + ADDR_W'(1);
                        for (int j = 0; j < PIX_PER_WORD; j++) begin
                            pbuf[j]                <= pbuf[j+PIX_PER_WORD];
                            pbuf[j+PIX_PER_WORD]   <= '0;
                        end
                        fill <= fill_rem;
`ifdef MEDF_STATS_EN
                        stat_pix <= stat_pix + 32'(word_pix);
`endif
                        if (!last_step) begin
                            wr_en   <= 1'b0;
                            win_req <= 1'b1;
                            state   <= S_REQ;
                        end else if (fill_rem == '0) begin
                            wr_en <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
`ifdef MEDF_STATS_EN
                    else stat_stall <= stat_stall + 32'd1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
